sync_cell_arb: RTL and testbench
================================

# sync_cell_arb

Parametrised successor to the shared sync cell: a single DATA_BITS register shared by ACTORS requesters, guarded by a lock that is granted to one actor at a time. Adds a selectable round-robin or fixed-priority arbitration mode, per-actor write enables, a one-hot grant vector, and an optional hold-timeout that forces release when other actors are waiting. It sits between solution datapath actors and a shared accumulator or state word.

## Interface
Parameters:
- ACTORS, 4, number of requesters (≥2)
- DATA_BITS, 8, width of the shared register
- RST_VAL, '0, value of data_out after reset
- ROUND_ROBIN, 1'b1, 1 = rotating priority, 0 = fixed priority (lowest index wins)
- MAX_HOLD, 0, cycles an owner may hold the lock while others request; 0 = unlimited
- LT_BITS (localparam) = max(1, $clog2(ACTORS))

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- lock_reqs  input  ACTORS  per-actor lock request, level
- write_ens  input  ACTORS  per-actor write enable; honoured only for the current owner
- data_inputs  input  ACTORS*DATA_BITS  packed; actor i at [i*DATA_BITS +: DATA_BITS]
- is_locked  output  1  lock currently held
- locked_to  output  LT_BITS  owner index; holds last owner when unlocked
- grant  output  ACTORS  one-hot owner, all-zero when unlocked
- data_out  output  DATA_BITS  shared register value
- timeout  output  1  one-cycle pulse on forced release

## Operation
- Two states: IDLE (is_locked=0), LOCKED (is_locked=1).
- Reset (rst_n=0, async, takes effect immediately): IDLE, locked_to=0, grant=0, data_out=RST_VAL, timeout=0, hold counter=0, rotation pointer=0, mask=0.
- IDLE: if (lock_reqs & ~mask) != 0, go LOCKED, locked_to/grant = winner, hold counter=0, mask cleared. Otherwise stay; mask cleared.
- Winner, fixed mode: lowest set index. Round-robin mode: first set index searching upward from (pointer), wrapping ACTORS-1 -> 0; pointer = last owner + 1 mod ACTORS, updated on every grant.
- LOCKED, owner still requesting: if write_ens[owner], data_out <= owner's data slice; else data_out holds. Hold counter increments, saturating at MAX_HOLD.
- LOCKED, owner drops request: go IDLE on that edge; no write occurs that edge even if write_ens[owner]=1. No re-grant on the same edge.
- Timeout (MAX_HOLD>0 only): if in LOCKED, owner still requesting, hold counter == MAX_HOLD-1 at the edge, and any other actor requests: the write (if enabled) still commits, then go IDLE, timeout=1 for one cycle, mask = one-hot of the expired owner (excluded from the next arbitration only). If no other actor requests, the owner keeps the lock indefinitely and the counter saturates.
- Write enables of non-owners are ignored in all states; in IDLE no write occurs.
- Data capture is a plain register load, no arithmetic; width exactly DATA_BITS.

## Timing
- Request to grant: 1 cycle (req sampled at edge N, is_locked=1 after edge N).
- Owner write to data_out: 1 cycle, starting the edge after grant.
- Release: owner deasserts before edge N; is_locked=0 after edge N; earliest new grant after edge N+1 (one mandatory idle cycle).
- Timeout: owner holds exactly MAX_HOLD LOCKED cycles, then one idle cycle, then next grant.
- locked_to and grant change only on grant edges; grant=0 whenever is_locked=0.
- Reset asserted mid-lock: all outputs return to reset values asynchronously; after release, first grant needs one edge with a request.

## Test plan
- Reset: hold rst_n=0 with all requests high -> is_locked=0, grant=0, locked_to=0, data_out=RST_VAL(0x00); release -> grant=4'b0001 after next edge.
- Fixed mode, lock_reqs=4'b1010, write_ens=4'b1010, data 3=0x5A, 1=0xC3 -> locked_to=1, data_out=0xC3 one edge later; actor 3's data never appears while 1 holds.
- Round-robin, all four requesting, each drops request after 2 locked cycles -> grant sequence 0,1,2,3,0 with one idle cycle between each.
- MAX_HOLD=3, actor 0 and 2 requesting continuously -> actor 0 locked 3 cycles, timeout pulse, idle cycle, actor 2 granted even in fixed mode.
- MAX_HOLD=3, only actor 1 requesting for 10 cycles -> lock held throughout, no timeout pulse.
- rst_n pulsed low mid-write while actor 2 locked with data 0xFF -> data_out=RST_VAL immediately, is_locked=0, grant=0 without waiting for a clock edge.

Source files
------------

// File: rtl/sync_cell_arb.sv
`default_nettype none
// ============================================================================
// Module   : sync_cell_arb
// Purpose  : Shared DATA_BITS register guarded by a lock arbitrated among
//            ACTORS requesters (round-robin or fixed priority, optional
//            hold-timeout forcing release when others are waiting).
// Revision : 1.0  initial release
// ============================================================================
module sync_cell_arb #(
    parameter int                    ACTORS      = 4,
    parameter int                    DATA_BITS   = 8,
    parameter logic [DATA_BITS-1:0]  RST_VAL     = '0,
    parameter bit                    ROUND_ROBIN = 1'b1,
    parameter int                    MAX_HOLD    = 0,
    localparam int                   LT_BITS     = (ACTORS > 2) ? $clog2(ACTORS) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [ACTORS-1:0]             lock_reqs,
    input  logic [ACTORS-1:0]             write_ens,
    input  logic [ACTORS*DATA_BITS-1:0]   data_inputs,
    output logic                          is_locked,
    output logic [LT_BITS-1:0]            locked_to,
    output logic [ACTORS-1:0]             grant,
    output logic [DATA_BITS-1:0]          data_out,
    output logic                          timeout
);

    localparam int HOLD_W    = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam int HOLD_LAST = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;

    localparam logic [HOLD_W-1:0] c_HOLD_MAX  = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] c_HOLD_LAST = HOLD_W'(HOLD_LAST);
    localparam logic [ACTORS-1:0] c_ONE       = ACTORS'(1);
    localparam bit                c_TO_EN     = (MAX_HOLD > 0);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [LT_BITS-1:0]     owner_q, owner_d;
    logic [LT_BITS-1:0]     ptr_q, ptr_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic [HOLD_W-1:0]      hold_q, hold_d;
    logic [ACTORS-1:0]      mask_q, mask_d;
    logic                   timeout_q, timeout_d;

    logic [DATA_BITS-1:0]   w_slice [ACTORS];
    logic [ACTORS-1:0]      w_elig;
    logic [ACTORS-1:0]      w_owner_oh;
    logic [LT_BITS-1:0]     w_winner;
    logic [LT_BITS-1:0]     w_idx;
    int                     w_sum;
    logic                   w_found;
    logic                   w_owner_req;
    logic                   w_owner_we;
    logic                   w_others;
    logic                   w_expire;

    generate
        for (genvar gi = 0; gi < ACTORS; gi++) begin : g_slice
            assign w_slice[gi] = data_inputs[gi*DATA_BITS +: DATA_BITS];
        end
    endgenerate

    // A timed-out owner is masked out of the single arbitration that follows.
    assign w_elig = lock_reqs & ~mask_q;

    always_comb begin
        w_winner = '0;
        w_found  = 1'b0;
        w_sum    = 0;
        w_idx    = '0;
        for (int k = 0; k < ACTORS; k++) begin
            if (ROUND_ROBIN) begin
                w_sum = int'(ptr_q) + k;
                if (w_sum >= ACTORS) begin
                    w_sum = w_sum - ACTORS;
                end
            end else begin
                w_sum = k;
            end
            w_idx = LT_BITS'(w_sum);
            if (!w_found && w_elig[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    assign w_owner_oh  = c_ONE << owner_q;
    assign w_owner_req = lock_reqs[owner_q];
    assign w_owner_we  = write_ens[owner_q];
    assign w_others    = |(lock_reqs & ~w_owner_oh);
    assign w_expire    = c_TO_EN && (hold_q == c_HOLD_LAST) && w_others;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        data_d    = data_q;
        hold_d    = hold_q;
        mask_d    = mask_q;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                mask_d = '0;
                if (w_found) begin
                    state_d = ST_LOCKED;
                    owner_d = w_winner;
                    hold_d  = '0;
                    ptr_d   = (int'(w_winner) == ACTORS - 1) ? '0 : w_winner + 1'b1;
                end
            end
            ST_LOCKED: begin
                if (!w_owner_req) begin
                    state_d = ST_IDLE;
                end else begin
                    if (w_owner_we) begin
                        data_d = w_slice[owner_q];
                    end
                    if (hold_q != c_HOLD_MAX) begin
                        hold_d = hold_q + 1'b1;
                    end
                    // The final write of an expiring owner still commits.
                    if (w_expire) begin
                        state_d   = ST_IDLE;
                        timeout_d = 1'b1;
                        mask_d    = w_owner_oh;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            owner_q   <= '0;
            ptr_q     <= '0;
            data_q    <= RST_VAL;
            hold_q    <= '0;
            mask_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            data_q    <= data_d;
            hold_q    <= hold_d;
            mask_q    <= mask_d;
            timeout_q <= timeout_d;
        end
    end

    assign is_locked = (state_q == ST_LOCKED);
    assign locked_to = owner_q;
    assign grant     = is_locked ? w_owner_oh : '0;
    assign data_out  = data_q;
    assign timeout   = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_sync_cell_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_cell_arb
// Purpose  : Self-checking bench for sync_cell_arb; three configurations
//            (round-robin, fixed, fixed with MAX_HOLD=3) share one stimulus.
// Revision : 1.0  initial release
// ============================================================================
module tb_sync_cell_arb;

    logic        clk;
    logic        rst_n;
    logic [3:0]  reqs;
    logic [3:0]  wes;
    logic [31:0] din;

    logic        o_lk [3];
    logic [1:0]  o_lt [3];
    logic [3:0]  o_gr [3];
    logic [7:0]  o_do [3];
    logic        o_to [3];

    int n_cmp = 0;
    int n_bad = 0;

    sync_cell_arb #(.ACTORS(4), .DATA_BITS(8), .RST_VAL(8'h00), .ROUND_ROBIN(1'b1), .MAX_HOLD(0)) u_rr (
        .clk(clk), .rst_n(rst_n), .lock_reqs(reqs), .write_ens(wes), .data_inputs(din),
        .is_locked(o_lk[0]), .locked_to(o_lt[0]), .grant(o_gr[0]), .data_out(o_do[0]), .timeout(o_to[0]));
    sync_cell_arb #(.ACTORS(4), .DATA_BITS(8), .RST_VAL(8'h00), .ROUND_ROBIN(1'b0), .MAX_HOLD(0)) u_fx (
        .clk(clk), .rst_n(rst_n), .lock_reqs(reqs), .write_ens(wes), .data_inputs(din),
        .is_locked(o_lk[1]), .locked_to(o_lt[1]), .grant(o_gr[1]), .data_out(o_do[1]), .timeout(o_to[1]));
    sync_cell_arb #(.ACTORS(4), .DATA_BITS(8), .RST_VAL(8'h00), .ROUND_ROBIN(1'b0), .MAX_HOLD(3)) u_to (
        .clk(clk), .rst_n(rst_n), .lock_reqs(reqs), .write_ens(wes), .data_inputs(din),
        .is_locked(o_lk[2]), .locked_to(o_lt[2]), .grant(o_gr[2]), .data_out(o_do[2]), .timeout(o_to[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: lock ownership as plain integers, one entry per instance.
    typedef struct {
        logic       locked;
        int         owner;
        logic [7:0] data;
        int         held;
        int         ptr;
        int         excl;
        logic       tmo;
    } mdl_t;

    mdl_t m [3];
    int   c_rr [3] = '{1, 0, 0};
    int   c_mh [3] = '{0, 0, 3};

    function automatic void mdl_reset();
        for (int k = 0; k < 3; k++) begin
            m[k].locked = 1'b0;
            m[k].owner  = 0;
            m[k].data   = 8'h00;
            m[k].held   = 0;
            m[k].ptr    = 0;
            m[k].excl   = -1;
            m[k].tmo    = 1'b0;
        end
    endfunction

    function automatic void mdl_step(int k, logic [3:0] r, logic [3:0] w, logic [31:0] d);
        logic [3:0] elig;
        int         win;
        m[k].tmo = 1'b0;
        if (!m[k].locked) begin
            elig = r;
            if (m[k].excl >= 0) elig[m[k].excl] = 1'b0;
            m[k].excl = -1;
            win = -1;
            for (int j = 0; j < 4; j++) begin
                int cand;
                cand = (c_rr[k] != 0) ? (m[k].ptr + j) % 4 : j;
                if (win < 0 && elig[cand]) win = cand;
            end
            if (win >= 0) begin
                m[k].locked = 1'b1;
                m[k].owner  = win;
                m[k].held   = 0;
                m[k].ptr    = (win + 1) % 4;
            end
        end else if (!r[m[k].owner]) begin
            m[k].locked = 1'b0;
        end else begin
            if (w[m[k].owner]) m[k].data = d[m[k].owner*8 +: 8];
            if (c_mh[k] > 0 && m[k].held == c_mh[k] - 1 &&
                (r & ~(4'b0001 << m[k].owner)) != 4'b0000) begin
                m[k].locked = 1'b0;
                m[k].tmo    = 1'b1;
                m[k].excl   = m[k].owner;
            end
            if (m[k].held < c_mh[k]) m[k].held = m[k].held + 1;
        end
    endfunction

    function automatic logic [15:0] exp_bundle(int k);
        logic [3:0] g;
        g = m[k].locked ? (4'b0001 << m[k].owner) : 4'b0000;
        return {m[k].locked, m[k].owner[1:0], g, m[k].data, m[k].tmo};
    endfunction

    function automatic logic [15:0] dut_bundle(int k);
        return {o_lk[k], o_lt[k], o_gr[k], o_do[k], o_to[k]};
    endfunction

    task automatic drive_edge(input logic [3:0] r, input logic [3:0] w, input logic [31:0] d);
        reqs = r;
        wes  = w;
        din  = d;
        for (int k = 0; k < 3; k++) mdl_step(k, r, w, d);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        reqs  = 4'hF;
        wes   = 4'hF;
        din   = 32'hFFFF_FFFF;
        mdl_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (dut_bundle(k) !== 16'h0000) begin
                n_bad++;
                $display("FAIL reset_state inst%0d: got %h, required 0000", k, dut_bundle(k));
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive_edge(4'hF, 4'h0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if ({o_lk[k], o_gr[k]} !== 5'b1_0001) begin
                n_bad++;
                $display("FAIL first_grant inst%0d: got lk=%b gr=%b, required lk=1 gr=0001", k, o_lk[k], o_gr[k]);
            end
        end
    endtask

    task automatic test_fixed_priority();
        logic [31:0] d;
        drive_edge(4'h0, 4'h0, 32'h0);
        drive_edge(4'h0, 4'h0, 32'h0);
        d = {8'h5A, 8'h00, 8'hC3, 8'h00};
        drive_edge(4'b1010, 4'b1010, d);
        n_cmp++;
        if ({o_lk[1], o_lt[1], o_gr[1], o_do[1]} !== {1'b1, 2'd1, 4'b0010, 8'h00}) begin
            n_bad++;
            $display("FAIL fixed_grant: got lk=%b lt=%0d gr=%b do=%h, required 1 1 0010 00",
                     o_lk[1], o_lt[1], o_gr[1], o_do[1]);
        end
        for (int i = 0; i < 4; i++) begin
            drive_edge(4'b1010, 4'b1010, d);
            n_cmp++;
            if ({o_lt[1], o_do[1]} !== {2'd1, 8'hC3}) begin
                n_bad++;
                $display("FAIL fixed_write cyc%0d: got lt=%0d do=%h, required lt=1 do=c3", i, o_lt[1], o_do[1]);
            end
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (dut_bundle(k) !== exp_bundle(k)) begin
                    n_bad++;
                    $display("FAIL fixed_model inst%0d: got %h, required %h", k, dut_bundle(k), exp_bundle(k));
                end
            end
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] d;
        drive_edge(4'h0, 4'h0, 32'h0);
        drive_edge(4'h0, 4'h0, 32'h0);
        d = 32'h00FF_0000;
        drive_edge(4'b0100, 4'b0100, d);
        drive_edge(4'b0100, 4'b0100, d);
        n_cmp++;
        if ({o_lk[1], o_lt[1], o_do[1]} !== {1'b1, 2'd2, 8'hFF}) begin
            n_bad++;
            $display("FAIL pre_reset_write: got lk=%b lt=%0d do=%h, required 1 2 ff", o_lk[1], o_lt[1], o_do[1]);
        end
        #2;
        rst_n = 1'b0;
        mdl_reset();
        #1;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if ({o_lk[k], o_gr[k], o_lt[k], o_do[k], o_to[k]} !== 16'h0000) begin
                n_bad++;
                $display("FAIL async_reset inst%0d: got lk=%b gr=%b lt=%0d do=%h to=%b, required all zero",
                         k, o_lk[k], o_gr[k], o_lt[k], o_do[k], o_to[k]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        reqs  = 4'h0;
    endtask

    task automatic test_round_robin();
        int e;
        for (int i = 0; i < 5; i++) begin
            e = i % 4;
            drive_edge(4'hF, 4'($urandom_range(0, 15)), $urandom);
            n_cmp++;
            if ({o_lk[0], o_lt[0], o_gr[0]} !== {1'b1, 2'(e), 4'(4'b0001 << e)}) begin
                n_bad++;
                $display("FAIL rr_grant step%0d: got lk=%b lt=%0d gr=%b, required lk=1 lt=%0d", i, o_lk[0], o_lt[0], o_gr[0], e);
            end
            drive_edge(4'hF, 4'($urandom_range(0, 15)), $urandom);
            drive_edge(4'hF & ~(4'b0001 << e), 4'($urandom_range(0, 15)), $urandom);
            n_cmp++;
            if ({o_lk[0], o_lt[0], o_gr[0]} !== {1'b0, 2'(e), 4'b0000}) begin
                n_bad++;
                $display("FAIL rr_release step%0d: got lk=%b lt=%0d gr=%b, required lk=0 lt=%0d gr=0000", i, o_lk[0], o_lt[0], o_gr[0], e);
            end
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (dut_bundle(k) !== exp_bundle(k)) begin
                    n_bad++;
                    $display("FAIL rr_model inst%0d: got %h, required %h", k, dut_bundle(k), exp_bundle(k));
                end
            end
        end
    endtask

    task automatic test_timeout();
        logic [3:0] exp_row [5];
        exp_row = '{4'b1_00_0, 4'b1_00_0, 4'b1_00_0, 4'b0_00_1, 4'b1_10_0};
        drive_edge(4'h0, 4'h0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            drive_edge(4'b0101, 4'b0101, $urandom);
            n_cmp++;
            if ({o_lk[2], o_lt[2], o_to[2]} !== exp_row[i]) begin
                n_bad++;
                $display("FAIL timeout step%0d: got lk/lt/to=%b, required %b", i, {o_lk[2], o_lt[2], o_to[2]}, exp_row[i]);
            end
            n_cmp++;
            if (dut_bundle(1) !== exp_bundle(1)) begin
                n_bad++;
                $display("FAIL timeout_fixed_model step%0d: got %h, required %h", i, dut_bundle(1), exp_bundle(1));
            end
        end
    endtask

    task automatic test_no_timeout();
        drive_edge(4'h0, 4'h0, 32'h0);
        for (int i = 0; i < 10; i++) begin
            drive_edge(4'b0010, 4'($urandom_range(0, 15)), $urandom);
            n_cmp++;
            if ({o_lk[2], o_lt[2], o_to[2]} !== 4'b1_01_0) begin
                n_bad++;
                $display("FAIL no_timeout cyc%0d: got lk/lt/to=%b, required 1010", i, {o_lk[2], o_lt[2], o_to[2]});
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] r;
        r = 4'h0;
        for (int i = 0; i < 400; i++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
            end
            drive_edge(r, 4'($urandom_range(0, 15)), $urandom);
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (dut_bundle(k) !== exp_bundle(k)) begin
                    n_bad++;
                    $display("FAIL random cyc%0d inst%0d: got %h, required %h", i, k, dut_bundle(k), exp_bundle(k));
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        reqs  = 4'h0;
        wes   = 4'h0;
        din   = 32'h0;
        test_reset();
        test_fixed_priority();
        test_async_reset();
        test_round_robin();
        test_timeout();
        test_no_timeout();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1);
    end

endmodule
`default_nettype wire
